// File: rtl/lab2_pkg.sv
// Shared constants and FSM encoding for the RAM access controller.
package lab2_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        W_ADDR,
        W_COMMIT,
        FILL
    } state_t;
endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, restarting from 0 on reset.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CNT_LAST);
endmodule

// File: rtl/ram_access_ctrl.sv
// Drives the registered-address 32x3 RAM wrapper: ticked read scan with address tags,
// single manual writes via req/ack, and whole-memory fill. wraddress leads wren/datain by one cycle.
module ram_access_ctrl
    import lab2_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scan_en,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] rdaddress,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] datain,
    output logic              wren,
    output logic              enable,
    output logic              busy,
    output logic              wr_ack,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_tag
);
    localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);

    logic tick;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    state_t            state_q, state_d;
    logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
    logic              step_q, step_d;
    logic              enable_q, enable_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0] pipe_tag_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_tag_d [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rdaddress_q <= '0;
            step_q      <= 1'b0;
            enable_q    <= 1'b0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rdaddress_q <= rdaddress_d;
            step_q      <= step_d;
            enable_q    <= enable_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= pipe_tag_d[i];
        end
    end

    // Scan pointer and read-tag pipeline; stage 0 samples the address the cycle after it moves.
    always_comb begin
        enable_d    = 1'b1;
        step_d      = tick & scan_en;
        rdaddress_d = step_d ? rdaddress_q + ADDR_W'(1) : rdaddress_q;
        pipe_vld_d    = '0;
        pipe_vld_d[0] = step_q;
        pipe_tag_d[0] = rdaddress_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    wr_data_d  = fill_data;
                end else if (wr_req) begin
                    state_d   = W_ADDR;
                    wr_addr_d = wr_addr_in;
                    wr_data_d = wr_data_in;
                end
            end
            W_ADDR:   state_d = W_COMMIT;
            W_COMMIT: state_d = IDLE;
            FILL: begin
                if (fill_cnt_q == FILL_LAST) state_d = IDLE;
                else                         fill_cnt_d = fill_cnt_q + (ADDR_W + 1)'(1);
            end
            default:  state_d = IDLE;
        endcase
    end

    // Fill presents address k on F(k) and commits it on F(k+1); F32 holds the last address.
    always_comb begin
        wraddress = '0;
        datain    = '0;
        wren      = 1'b0;
        busy      = 1'b0;
        wr_ack    = 1'b0;
        case (state_q)
            W_ADDR: begin
                wraddress = wr_addr_q;
                busy      = 1'b1;
            end
            W_COMMIT: begin
                wraddress = wr_addr_q;
                datain    = wr_data_q;
                wren      = 1'b1;
                wr_ack    = 1'b1;
                busy      = 1'b1;
            end
            FILL: begin
                wraddress = (fill_cnt_q == FILL_LAST) ? ADDR_MAX : fill_cnt_q[ADDR_W-1:0];
                datain    = wr_data_q;
                wren      = (fill_cnt_q != '0);
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign rdaddress = rdaddress_q;
    assign enable    = enable_q;
    assign rd_valid  = pipe_vld_q[RD_LAT-1];
    assign rd_tag    = pipe_tag_q[RD_LAT-1];
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a behavioural registered-address RAM and a read scoreboard.
module tb_ram_access_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scan_en = 1'b0;
    logic       wr_req = 1'b0;
    logic [4:0] wr_addr_in = '0;
    logic [2:0] wr_data_in = '0;
    logic       fill_start = 1'b0;
    logic [2:0] fill_data = '0;
    logic [4:0] rdaddress, wraddress, rd_tag;
    logic [2:0] datain;
    logic       wren, enable, busy, wr_ack, rd_valid;

    ram_access_ctrl #(.TICK_DIV(4), .RD_LAT(2)) dut (
        .clock(clock), .reset(reset), .scan_en(scan_en), .wr_req(wr_req),
        .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .fill_start(fill_start),
        .fill_data(fill_data), .rdaddress(rdaddress), .wraddress(wraddress),
        .datain(datain), .wren(wren), .enable(enable), .busy(busy), .wr_ack(wr_ack),
        .rd_valid(rd_valid), .rd_tag(rd_tag)
    );

    always #5 clock = ~clock;

    // RAM wrapper: addresses registered under enable, data/wren unregistered, registered dataout.
    logic [2:0] mem [32];
    logic [4:0] ra_q = '0, wa_q = '0;
    logic [2:0] ram_dout = '0;
    always @(posedge clock) begin
        if (enable) begin
            ra_q <= rdaddress;
            wa_q <= wraddress;
        end
        if (wren) mem[wa_q] <= datain;
        ram_dout <= mem[ra_q];
    end

    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  tag;
        int unsigned due;
    } rd_exp_t;
    rd_exp_t     rdq[$];
    logic [2:0]  exp_mem [32];
    logic [4:0]  exp_rd = '0;
    int unsigned tcnt = 0;
    int unsigned cyc = 0;
    int unsigned rv_cnt = 0;

    // Scan model: expected tag pushed on each modelled tick, due two cycles after the step.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            tcnt   = 0;
            exp_rd = '0;
            rdq.delete();
        end else begin
            if (tcnt == 3 && scan_en) begin
                exp_rd = exp_rd + 5'd1;
                rdq.push_back('{exp_rd, cyc + 2});
            end
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(negedge clock) begin
        if (rd_valid) begin
            rv_cnt++;
            if (rdq.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rdq.pop_front();
                chk("rd_tag", 32'(rd_tag), 32'(e.tag));
                chk("rd_data", 32'(ram_dout), 32'(exp_mem[e.tag]));
                chk("rd_cycle", cyc, e.due);
            end
        end
    end

    task automatic scan_pass(input int n);
        scan_en = 1'b1;
        repeat (n) @(negedge clock);
        scan_en = 1'b0;
        repeat (8) @(negedge clock);
        chk("rd_drain", 32'(rdq.size()), 32'd0);
        chk("rdaddress", 32'(rdaddress), 32'(exp_rd));
    endtask

    // Fill pulse, optionally with a simultaneous manual write request held until acked.
    task automatic run_fill(input logic [2:0] fd, input bit with_req,
                            input logic [4:0] wa, input logic [2:0] wd);
        int nb = 0, nw = 0, bad = 0, acks = 0, ack_idx = -1;
        logic [4:0] wa_first = '0, wa_last = '0;
        fill_data  = fd;
        fill_start = 1'b1;
        if (with_req) begin
            wr_req = 1'b1; wr_addr_in = wa; wr_data_in = wd;
        end
        @(negedge clock);
        fill_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && i <= 33) nb++;
            if (wren && !wr_ack) begin
                nw++;
                if (nw == 1) wa_first = wraddress;
                wa_last = wraddress;
                if (wraddress != ((nw < 32) ? 5'(nw) : 5'd31)) bad++;
            end
            if (wr_ack) begin
                acks++;
                if (ack_idx < 0) ack_idx = i;
                wr_req = 1'b0;
            end
            @(negedge clock);
        end
        chk("fill_busy_cycles", 32'(nb), 32'd33);
        chk("fill_wren_cycles", 32'(nw), 32'd32);
        chk("fill_wa_first", 32'(wa_first), 32'd1);
        chk("fill_wa_last", 32'(wa_last), 32'd31);
        chk("fill_wa_seq_bad", 32'(bad), 32'd0);
        chk("fill_acks", 32'(acks), with_req ? 32'd1 : 32'd0);
        if (with_req) chk("fill_then_write_ack_idx", 32'(ack_idx), 32'd35);
        for (int a = 0; a < 32; a++) exp_mem[a] = fd;
        if (with_req) exp_mem[wa] = wd;
    endtask

    initial begin
        int rv0;
        for (int a = 0; a < 32; a++) begin
            mem[a]     = '0;
            exp_mem[a] = '0;
        end
        repeat (3) @(negedge clock);
        chk("rst_rdaddress", 32'(rdaddress), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_wraddress", 32'(wraddress), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("enable_after_rst", 32'(enable), 32'd1);

        // Scan with wrap past 31.
        scan_pass(140);

        // Freeze for 10 ticks: pointer static, no reads.
        rv0 = rv_cnt;
        repeat (40) @(negedge clock);
        chk("freeze_rd_valid", 32'(rv_cnt - rv0), 32'd0);
        chk("freeze_rdaddress", 32'(rdaddress), 32'(exp_rd));

        // Manual write of 101 to address 5.
        wr_req = 1'b1; wr_addr_in = 5'd5; wr_data_in = 3'b101;
        @(negedge clock);
        chk("wa_busy", 32'(busy), 32'd1);
        chk("wa_wraddress", 32'(wraddress), 32'd5);
        chk("wa_wren", 32'(wren), 32'd0);
        chk("wa_ack", 32'(wr_ack), 32'd0);
        @(negedge clock);
        chk("wc_wren", 32'(wren), 32'd1);
        chk("wc_datain", 32'(datain), 32'b101);
        chk("wc_ack", 32'(wr_ack), 32'd1);
        chk("wc_wraddress", 32'(wraddress), 32'd5);
        wr_req = 1'b0;
        exp_mem[5] = 3'b101;
        @(negedge clock);
        chk("wdone_busy", 32'(busy), 32'd0);
        scan_pass(136);

        // Full fill, then fill with a concurrent write request.
        run_fill(3'b111, 1'b0, 5'd0, 3'd0);
        scan_pass(136);
        run_fill(3'b111, 1'b1, 5'd9, 3'b010);
        scan_pass(136);

        // Reset sampled at the edge that would begin F10.
        fill_data  = 3'b011;
        fill_start = 1'b1;
        @(negedge clock);
        fill_start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_wren", 32'(wren), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdaddress", 32'(rdaddress), 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 9; a++) exp_mem[a] = 3'b011;
        @(negedge clock);
        scan_pass(136);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Upstream control stage for the registered-address 32x3 dual-port RAM wrapper.
- Drives its rdaddress/wraddress/datain/wren/enable inputs.
- Scans read addresses 0..31 at a divided tick rate.
- Services single manual writes from switch inputs through a request/ack handshake.
- Performs a whole-memory fill; tags returning read data with its address.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32
- DATA_W, 3, RAM word width
- TICK_DIV, 50_000_000, clock cycles per scan step (1 s at 50 MHz); bench uses 4
- RD_LAT, 2, cycles from rdaddress change to valid RAM dataout (1 address register + 1 RAM)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- scan_en  in  1  1 = read scan advances on each tick
- wr_req  in  1  level request for one manual write; hold until wr_ack
- wr_addr_in  in  ADDR_W  manual write address
- wr_data_in  in  DATA_W  manual write data
- fill_start  in  1  pulse; write fill_data to all 32 entries
- fill_data  in  DATA_W  fill value
- rdaddress  out  ADDR_W  to RAM wrapper read address
- wraddress  out  ADDR_W  to RAM wrapper write address
- datain  out  DATA_W  to RAM wrapper write data
- wren  out  1  to RAM wrapper write enable
- enable  out  1  to RAM wrapper address-register enable
- busy  out  1  fill or manual write in progress
- wr_ack  out  1  one-cycle pulse when a manual write commits
- rd_valid  out  1  one-cycle pulse when RAM dataout corresponds to rd_tag
- rd_tag  out  ADDR_W  address whose data is on RAM dataout while rd_valid=1

Behaviour:
- Reset values: all outputs 0; state IDLE; tick counter 0; scan pointer 0.
- enable is registered; 1 from the first cycle after reset deasserts.
- Write alignment: the RAM wrapper registers addresses but not wren/datain. wraddress must therefore lead wren/datain by exactly one cycle, and be held through the commit cycle.
- Tick: counter runs 0..TICK_DIV-1 whenever not in reset; tick = 1 when the counter is TICK_DIV-1.
- On a tick with scan_en=1: rdaddress <= rdaddress+1, wrapping 31->0.
- scan_en=0 freezes rdaddress; the counter keeps running.
- Read tracking: an RD_LAT-deep shift register carries (change flag, rdaddress) from each rdaddress update. rd_valid/rd_tag emerge RD_LAT cycles later. Scanning is independent of the write FSM.
- FSM states: IDLE, W_ADDR, W_COMMIT, FILL.
- IDLE:
  - fill_start=1 -> FILL; fill_cnt <= 0. fill has priority when fill_start and wr_req are both 1.
  - else wr_req=1 -> W_ADDR; latch wr_addr_in and wr_data_in.
  - wren=0, busy=0.
- W_ADDR: wraddress = latched address; wren=0; busy=1; -> W_COMMIT.
- W_COMMIT:
  - wren=1; datain = latched data; wraddress held; wr_ack=1; busy=1.
  - -> IDLE. A still-held wr_req in the following IDLE cycle starts a new write; requester drops wr_req on seeing wr_ack.
- FILL:
  - wraddress = fill_cnt, stepping 0..31 on fill cycles F0..F31.
  - wren = 1 on F1..F32, writing address k on cycle F(k+1); datain = fill_data.
  - busy = 1 on F0..F32 (33 cycles); -> IDLE after F32.
  - fill_start or wr_req during FILL: ignored, not queued. A held wr_req is serviced after FILL.
- Reset mid-operation: next edge forces IDLE, wren=0, busy=0, rdaddress=0, and clears the read pipeline. Partially filled RAM contents are left as-is.
- All arithmetic is modulo 2**ADDR_W; no overflow flags.

Decomposition:
- Package lab2_pkg: ADDR_W, DATA_W, DEPTH=32 constants; state_t enum {IDLE, W_ADDR, W_COMMIT, FILL}.
- One sub-module, tick_divider (parameter TICK_DIV; ports clock, reset, tick). Instantiated once.
- Read-tag pipeline and FSM live in ram_access_ctrl.

Test Plan:
- Reset, then scan_en=1, TICK_DIV=4 -> rdaddress steps 0,1,2,... every 4 cycles; wraps 31->0 after 128 cycles. Each step yields rd_valid 2 cycles later with rd_tag equal to the new address.
- wr_req=1, wr_addr_in=5, wr_data_in=3'b101 -> W_ADDR next cycle with wraddress=5, wren=0. Following cycle: wren=1, datain=101, wr_ack=1. A scan read of address 5 then returns 101.
- fill_start pulse, fill_data=3'b111 -> busy high exactly 33 cycles; wren high 32 cycles with wren-cycle wraddress = k+1 for write k (final write at wraddress 31). All 32 subsequent scan reads return 111.
- fill_start and wr_req asserted in the same IDLE cycle -> FILL runs first, no wr_ack during it. Manual write commits 3 cycles after busy falls, overwriting only its address.
- reset asserted at fill cycle F10 -> next cycle wren=0, busy=0, rdaddress=0. Entries 0..8 hold fill_data; entries 9..31 are unchanged.
- scan_en=0 for 10 ticks -> rdaddress and rd_valid stay static. Re-enable -> advances from the held value.
